// File: rtl/osc_upd.sv
// osc_upd: time-multiplexed phase update engine and state store for an oscillator bank.
// Define OSC_UPD_TICK_QUEUE_EN to queue one tick that arrives during a sweep.
module osc_upd #(
    parameter int N = 10,
    parameter int W = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                wr_en,
    input  logic [5:0]          wr_num,
    input  logic [W-1:0]        wr_max,
    output logic [5:0]          osc_num,
    output logic [N-1:0][W-1:0] count,
    output logic [N-1:0][W-1:0] max,
    output logic [N-1:0]        wave,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              state_q, state_d;
    logic [5:0]          idx_q, idx_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic [N-1:0][W-1:0] count_q, count_d;
    logic [N-1:0][W-1:0] max_q, max_d;
    logic [N-1:0]        wave_q, wave_d;
    logic                last_osc;
`ifdef OSC_UPD_TICK_QUEUE_EN
    logic                pending_q, pending_d;
`endif

    assign last_osc = (idx_q == 6'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef OSC_UPD_TICK_QUEUE_EN
            pending_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
`ifdef OSC_UPD_TICK_QUEUE_EN
            pending_q <= pending_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
`ifdef OSC_UPD_TICK_QUEUE_EN
        pending_d = pending_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef OSC_UPD_TICK_QUEUE_EN
                // A queued tick restarts immediately; a fresh tick in that same cycle takes its place.
                if (tick || pending_q) begin
                    state_d   = SCAN;
                    idx_d     = '0;
                    pending_d = tick && pending_q;
                end
`else
                if (tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
`endif
            end
            SCAN: begin
                if (last_osc) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
                if (tick) begin
`ifdef OSC_UPD_TICK_QUEUE_EN
                    if (pending_q) overrun_d = 1'b1;
                    else           pending_d = 1'b1;
`else
                    overrun_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == SCAN);
        osc_num = idx_q;
        done    = done_q;
        overrun = overrun_q;
        count   = count_q;
        max     = max_q;
        wave    = wave_q;
    end

    // Host loads are applied after the sweep update so a same-oscillator collision favours the load.
    always_comb begin
        count_d = count_q;
        max_d   = max_q;
        wave_d  = wave_q;
        for (int i = 0; i < N; i++) begin
            if (state_q == SCAN && idx_q == 6'(i)) begin
                if (max_q[i] == '0) begin
                    count_d[i] = '0;
                    wave_d[i]  = 1'b0;
                end else if (count_q[i] >= max_q[i] - W'(1)) begin
                    count_d[i] = '0;
                    wave_d[i]  = ~wave_q[i];
                end else begin
                    count_d[i] = count_q[i] + W'(1);
                end
            end
            if (wr_en && wr_num == 6'(i)) begin
                max_d[i]   = wr_max;
                count_d[i] = '0;
                wave_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            max_q   <= '0;
            wave_q  <= '0;
        end else begin
            count_q <= count_d;
            max_q   <= max_d;
            wave_q  <= wave_d;
        end
    end

endmodule

// File: tb/tb_osc_upd.sv
// tb_osc_upd: table-driven directed checks of osc_upd plus hand-written sweep, collision,
// reset and tick-overlap sequences. Adapts to OSC_UPD_TICK_QUEUE_EN when it is defined.
module tb_osc_upd;
    localparam int N = 10;
    localparam int W = 20;

    logic                clk = 1'b0;
    logic                rst;
    logic                tick;
    logic                wrEn;
    logic [5:0]          wrNum;
    logic [W-1:0]        wrMax;
    logic [5:0]          oscNum;
    logic [N-1:0][W-1:0] oscCount;
    logic [N-1:0][W-1:0] oscMax;
    logic [N-1:0]        wave;
    logic                busy;
    logic                done;
    logic                overrun;

    int testsRun  = 0;
    int failCount = 0;

    typedef struct {
        logic         doLoad;
        logic [5:0]   num;
        logic [W-1:0] mx;
        int           sweeps;
        int           osc;
        logic [W-1:0] expCount;
        logic [W-1:0] expMax;
        logic         expWave;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    osc_upd #(.N(N), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .wr_en   (wrEn),
        .wr_num  (wrNum),
        .wr_max  (wrMax),
        .osc_num (oscNum),
        .count   (oscCount),
        .max     (oscMax),
        .wave    (wave),
        .busy    (busy),
        .done    (done),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyLoad(input logic [5:0] num, input logic [W-1:0] mx);
        @(negedge clk);
        wrEn  = 1'b1;
        wrNum = num;
        wrMax = mx;
        @(negedge clk);
        wrEn = 1'b0;
    endtask

    task automatic waitOscNum(input int k, input string name);
        logic found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tick = 1'b0;
            if (busy && oscNum == 6'(k)) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput(name, 32'(found), 32'd1);
    endtask

    task automatic waitDone(input string name);
        logic found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tick = 1'b0;
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput(name, 32'(found), 32'd1);
    endtask

    // One isolated sweep; done must arrive exactly N+1 cycles after the tick cycle.
    task automatic applyStimulus(input string name);
        int lat = -1;
        @(negedge clk);
        tick = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            tick = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        checkOutput(name, 32'(lat), 32'(N + 1));
    endtask

    task automatic checkSweepTiming(input string tag);
        @(negedge clk);
        tick = 1'b1;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            tick = 1'b0;
            checkOutput($sformatf("%s osc_num at step %0d", tag, k), 32'(oscNum), 32'(k));
            checkOutput($sformatf("%s busy at step %0d", tag, k), 32'(busy), 32'd1);
            checkOutput($sformatf("%s done low at step %0d", tag, k), 32'(done), 32'd0);
        end
        @(negedge clk);
        checkOutput({tag, " done pulse"}, 32'(done), 32'd1);
        checkOutput({tag, " busy after sweep"}, 32'(busy), 32'd0);
        checkOutput({tag, " osc_num after sweep"}, 32'(oscNum), 32'd0);
        @(negedge clk);
        checkOutput({tag, " done one cycle"}, 32'(done), 32'd0);
    endtask

    task automatic checkAllReset(input string tag);
        checkOutput({tag, " osc_num"}, 32'(oscNum), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " overrun"}, 32'(overrun), 32'd0);
        checkOutput({tag, " count any"}, 32'(|oscCount), 32'd0);
        checkOutput({tag, " max any"}, 32'(|oscMax), 32'd0);
        checkOutput({tag, " wave any"}, 32'(|wave), 32'd0);
    endtask

    initial begin
        // Osc 3 wraps every 3 sweeps; osc 5 is run then disabled; wr_num 12 must be ignored.
        vecs[0]  = '{1'b1, 6'd3,  20'd3, 1, 3, 20'd1, 20'd3, 1'b0};
        vecs[1]  = '{1'b0, 6'd0,  20'd0, 1, 3, 20'd2, 20'd3, 1'b0};
        vecs[2]  = '{1'b0, 6'd0,  20'd0, 1, 3, 20'd0, 20'd3, 1'b1};
        vecs[3]  = '{1'b0, 6'd0,  20'd0, 1, 3, 20'd1, 20'd3, 1'b1};
        vecs[4]  = '{1'b0, 6'd0,  20'd0, 1, 3, 20'd2, 20'd3, 1'b1};
        vecs[5]  = '{1'b0, 6'd0,  20'd0, 1, 3, 20'd0, 20'd3, 1'b0};
        vecs[6]  = '{1'b0, 6'd0,  20'd0, 1, 3, 20'd1, 20'd3, 1'b0};
        vecs[7]  = '{1'b0, 6'd0,  20'd0, 0, 0, 20'd0, 20'd0, 1'b0};
        vecs[8]  = '{1'b0, 6'd0,  20'd0, 0, 9, 20'd0, 20'd0, 1'b0};
        vecs[9]  = '{1'b1, 6'd5,  20'd2, 3, 5, 20'd1, 20'd2, 1'b1};
        vecs[10] = '{1'b1, 6'd5,  20'd0, 0, 5, 20'd0, 20'd0, 1'b0};
        vecs[11] = '{1'b0, 6'd0,  20'd0, 5, 5, 20'd0, 20'd0, 1'b0};
        vecs[12] = '{1'b1, 6'd12, 20'd7, 0, 3, 20'd0, 20'd3, 1'b1};
        vecs[13] = '{1'b0, 6'd0,  20'd0, 0, 2, 20'd0, 20'd0, 1'b0};
        vecs[14] = '{1'b0, 6'd0,  20'd0, 0, 4, 20'd0, 20'd0, 1'b0};

        rst   = 1'b1;
        tick  = 1'b0;
        wrEn  = 1'b0;
        wrNum = '0;
        wrMax = '0;
        repeat (2) @(negedge clk);
        checkAllReset("reset state");
        rst = 1'b0;
        checkSweepTiming("first sweep");

        for (int v = 0; v < NV; v++) begin
            if (vecs[v].doLoad) applyLoad(vecs[v].num, vecs[v].mx);
            for (int s = 0; s < vecs[v].sweeps; s++) applyStimulus($sformatf("vec%0d sweep latency", v));
            checkOutput($sformatf("vec%0d count[%0d]", v, vecs[v].osc), 32'(oscCount[vecs[v].osc]), 32'(vecs[v].expCount));
            checkOutput($sformatf("vec%0d max[%0d]", v, vecs[v].osc), 32'(oscMax[vecs[v].osc]), 32'(vecs[v].expMax));
            checkOutput($sformatf("vec%0d wave[%0d]", v, vecs[v].osc), 32'(wave[vecs[v].osc]), 32'(vecs[v].expWave));
        end

        applyLoad(6'd2, 20'd100);
        for (int s = 0; s < 50; s++) applyStimulus("collision preset sweep");
        checkOutput("collision preset count[2]", 32'(oscCount[2]), 32'd50);
        @(negedge clk);
        tick = 1'b1;
        waitOscNum(2, "collision reach osc 2");
        wrEn  = 1'b1;
        wrNum = 6'd2;
        wrMax = 20'd8;
        @(negedge clk);
        wrEn = 1'b0;
        waitDone("collision sweep done");
        checkOutput("collision count[2]", 32'(oscCount[2]), 32'd0);
        checkOutput("collision max[2]", 32'(oscMax[2]), 32'd8);
        checkOutput("collision wave[2]", 32'(wave[2]), 32'd0);

        // Osc 7 is loaded mid-sweep while osc 1 updates, then swept later in the same pass.
        applyLoad(6'd1, 20'd20);
        for (int s = 0; s < 9; s++) applyStimulus("lowered preset sweep");
        checkOutput("lowered preset count[1]", 32'(oscCount[1]), 32'd9);
        @(negedge clk);
        tick = 1'b1;
        waitOscNum(1, "parallel reach osc 1");
        wrEn  = 1'b1;
        wrNum = 6'd7;
        wrMax = 20'd5;
        @(negedge clk);
        wrEn = 1'b0;
        waitDone("parallel sweep done");
        checkOutput("parallel count[1]", 32'(oscCount[1]), 32'd10);
        checkOutput("parallel max[7]", 32'(oscMax[7]), 32'd5);
        checkOutput("parallel count[7]", 32'(oscCount[7]), 32'd1);
        checkOutput("parallel wave[1]", 32'(wave[1]), 32'd0);
        applyLoad(6'd1, 20'd4);
        checkOutput("reload count[1]", 32'(oscCount[1]), 32'd0);
        checkOutput("reload max[1]", 32'(oscMax[1]), 32'd4);
        for (int s = 0; s < 4; s++) applyStimulus("reload sweep");
        checkOutput("reload wrap count[1]", 32'(oscCount[1]), 32'd0);
        checkOutput("reload wrap wave[1]", 32'(wave[1]), 32'd1);
        checkOutput("osc7 wrap count[7]", 32'(oscCount[7]), 32'd0);
        checkOutput("osc7 wrap wave[7]", 32'(wave[7]), 32'd1);

        checkOutput("overrun before overlap", 32'(overrun), 32'd0);
        @(negedge clk);
        tick = 1'b1;
        waitOscNum(6, "overlap reach osc 6");
        tick = 1'b1;
        waitDone("overlap first done");
`ifdef OSC_UPD_TICK_QUEUE_EN
        checkOutput("queued overrun in done cycle", 32'(overrun), 32'd0);
        @(negedge clk);
        checkOutput("queued sweep busy", 32'(busy), 32'd1);
        checkOutput("queued sweep osc_num", 32'(oscNum), 32'd0);
        waitDone("queued sweep done");
        checkOutput("queued overrun after", 32'(overrun), 32'd0);
        @(negedge clk);
        tick = 1'b1;
        waitOscNum(4, "double reach osc 4");
        tick = 1'b1;
        waitOscNum(6, "double reach osc 6");
        tick = 1'b1;
        waitDone("double first done");
        checkOutput("double overrun", 32'(overrun), 32'd1);
        @(negedge clk);
        checkOutput("double pending sweep busy", 32'(busy), 32'd1);
        waitDone("double pending done");
        checkOutput("double overrun sticky", 32'(overrun), 32'd1);
`else
        checkOutput("dropped tick overrun", 32'(overrun), 32'd1);
        begin
            int busyCycles = 0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (busy) busyCycles++;
            end
            checkOutput("dropped tick no second sweep", 32'(busyCycles), 32'd0);
        end
        checkOutput("dropped tick overrun sticky", 32'(overrun), 32'd1);
`endif

        @(negedge clk);
        tick = 1'b1;
        waitOscNum(4, "reset reach osc 4");
        #2 rst = 1'b1;
        #1 checkAllReset("mid-sweep reset");
        @(negedge clk);
        rst = 1'b0;
        checkSweepTiming("post-reset sweep");

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
